// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, latch, execute and load write-back.
// Decodes the instruction register into datapath selects and strobes.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    output logic [1:0]  alu_a_select,
    output logic [1:0]  alu_b_select,
    output logic [2:0]  alu_operation,
    output logic        program_counter_write_enable,
    output logic [1:0]  program_counter_select,
    output logic        status_write_enable,
    output logic        instruction_write_enable,
    output logic        register_write_enable,
    output logic [2:0]  register_write_data_select,
    output logic [2:0]  register_write_data_select_extra,
    output logic        raycast_write_enable,
    output logic [2:0]  raycast_write_select,
    output logic [1:0]  memory_address_select,
    output logic [2:0]  memory_offset,
    output logic        memory_write_enable
);

    typedef enum logic [1:0] {FETCH, LATCH, EXECUTE, LOAD_WB} state_t;

    state_t      r_state;
    logic [3:0]  w_op;
    logic [3:0]  w_ext;
    logic        w_is_load;
    logic [3:0]  w_rr;
    logic [3:0]  w_imm;
    logic        w_unused;

    assign w_op      = instruction[15:12];
    assign w_ext     = instruction[7:4];
    assign w_is_load = (w_op == 4'b0100) && (w_ext == 4'b0000);
    assign w_unused  = ^{instruction[11:8], instruction[3:0]};

    // {valid, alu_operation}; the same code table serves RR ext and immediate op
    function automatic logic [3:0] alu_dec(input logic [3:0] c);
        case (c)
            4'b0101: alu_dec = 4'b1000;
            4'b1001: alu_dec = 4'b1001;
            4'b1011: alu_dec = 4'b1010;
            4'b0001: alu_dec = 4'b1011;
            4'b0010: alu_dec = 4'b1100;
            4'b0011: alu_dec = 4'b1101;
            default: alu_dec = 4'b0000;
        endcase
    endfunction

    assign w_rr  = alu_dec(w_ext);
    assign w_imm = alu_dec(w_op);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:   r_state <= LATCH;
                LATCH:   r_state <= EXECUTE;
                EXECUTE: r_state <= w_is_load ? LOAD_WB : FETCH;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign register_write_data_select_extra = 3'b000;
    assign raycast_write_enable             = 1'b0;
    assign raycast_write_select             = 3'b000;
    assign memory_offset                    = 3'b000;

    always_comb begin
        alu_a_select                 = 2'b00;
        alu_b_select                 = 2'b00;
        alu_operation                = 3'b000;
        program_counter_write_enable = 1'b0;
        program_counter_select       = 2'b00;
        status_write_enable          = 1'b0;
        instruction_write_enable     = 1'b0;
        register_write_enable        = 1'b0;
        register_write_data_select   = 3'b000;
        memory_address_select        = 2'b00;
        memory_write_enable          = 1'b0;
        case (r_state)
            LATCH: instruction_write_enable = 1'b1;
            EXECUTE: begin
                program_counter_write_enable = 1'b1;
                case (w_op)
                    4'b0000: begin
                        if (w_rr[3]) begin
                            alu_a_select          = 2'b01;
                            alu_operation         = w_rr[2:0];
                            register_write_enable = (w_rr[2:0] != 3'b010);
                            status_write_enable   = (w_rr[2:0] <= 3'b010);
                        end else if (w_ext == 4'b1101) begin
                            register_write_enable      = 1'b1;
                            register_write_data_select = 3'b001;
                        end
                    end
                    4'b1101: begin
                        register_write_enable      = 1'b1;
                        register_write_data_select = 3'b010;
                    end
                    4'b1111: begin
                        register_write_enable      = 1'b1;
                        register_write_data_select = 3'b011;
                    end
                    4'b1000: begin
                        if (w_ext == 4'b0100 || w_ext[3:1] == 3'b000) begin
                            alu_a_select          = (w_ext == 4'b0100) ? 2'b01 : 2'b10;
                            alu_operation         = 3'b110;
                            register_write_enable = 1'b1;
                        end
                    end
                    4'b1100: begin
                        alu_b_select           = 2'b10;
                        program_counter_select = 2'b01;
                    end
                    4'b0100: begin
                        if (w_ext == 4'b1100) begin
                            program_counter_select = 2'b10;
                        end else if (w_ext == 4'b0000) begin
                            memory_address_select = 2'b01;
                        end else if (w_ext == 4'b0100) begin
                            memory_address_select = 2'b01;
                            memory_write_enable   = 1'b1;
                        end
                    end
                    default: begin
                        if (w_imm[3]) begin
                            alu_a_select          = (w_imm[2:0] <= 3'b010) ? 2'b10 : 2'b11;
                            alu_operation         = w_imm[2:0];
                            register_write_enable = (w_imm[2:0] != 3'b010);
                            status_write_enable   = (w_imm[2:0] <= 3'b010);
                        end
                    end
                endcase
            end
            LOAD_WB: begin
                register_write_enable      = 1'b1;
                register_write_data_select = 3'b100;
                memory_address_select      = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small PC model driven by the
// control strobes; per-cycle output vectors are checked against hand values.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic [1:0]  alu_a_select, alu_b_select, program_counter_select;
    logic [2:0]  alu_operation, register_write_data_select;
    logic [2:0]  register_write_data_select_extra, raycast_write_select;
    logic [2:0]  memory_offset;
    logic [1:0]  memory_address_select;
    logic        program_counter_write_enable, status_write_enable;
    logic        instruction_write_enable, register_write_enable;
    logic        raycast_write_enable, memory_write_enable;

    int          total = 0;
    int          bad = 0;
    logic        taken = 1'b0;
    logic [15:0] pc;
    logic [28:0] obs;

    control_unit dut (
        .clock                            (clock),
        .reset                            (reset),
        .instruction                      (instruction),
        .alu_a_select                     (alu_a_select),
        .alu_b_select                     (alu_b_select),
        .alu_operation                    (alu_operation),
        .program_counter_write_enable     (program_counter_write_enable),
        .program_counter_select           (program_counter_select),
        .status_write_enable              (status_write_enable),
        .instruction_write_enable         (instruction_write_enable),
        .register_write_enable            (register_write_enable),
        .register_write_data_select       (register_write_data_select),
        .register_write_data_select_extra (register_write_data_select_extra),
        .raycast_write_enable             (raycast_write_enable),
        .raycast_write_select             (raycast_write_select),
        .memory_address_select            (memory_address_select),
        .memory_offset                    (memory_offset),
        .memory_write_enable              (memory_write_enable)
    );

    always #5 clock = ~clock;

    assign obs = {alu_a_select, alu_b_select, alu_operation,
                  program_counter_write_enable, program_counter_select,
                  status_write_enable, instruction_write_enable,
                  register_write_enable, register_write_data_select,
                  register_write_data_select_extra, raycast_write_enable,
                  raycast_write_select, memory_address_select,
                  memory_offset, memory_write_enable};

    // Datapath PC stand-in: branch target is PC+1 plus sign-extended disp
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= 16'd0;
        end else if (program_counter_write_enable) begin
            if (program_counter_select == 2'b01 && taken)
                pc <= pc + 16'd1 + {{8{instruction[7]}}, instruction[7:0]};
            else
                pc <= pc + 16'd1;
        end
    end

    function automatic logic [28:0] ev(
        input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
        input logic pcwe, input logic [1:0] pcs, input logic swe,
        input logic iwe, input logic rwe, input logic [2:0] rs,
        input logic [1:0] mas, input logic mwe);
        return {a, b, op, pcwe, pcs, swe, iwe, rwe, rs,
                3'b000, 1'b0, 3'b000, mas, 3'b000, mwe};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Starts at a negedge in FETCH, ends at the negedge of the next FETCH
    task automatic run(input string tag, input logic [15:0] ins,
                       input logic [28:0] ex, input logic ld,
                       input logic [28:0] wb);
        chk({tag, ".fetch"}, {3'b0, obs}, 32'd0);
        instruction = ins;
        @(posedge clock); @(negedge clock);
        chk({tag, ".latch"}, {3'b0, obs},
            {3'b0, ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        @(posedge clock); @(negedge clock);
        chk({tag, ".exec"}, {3'b0, obs}, {3'b0, ex});
        if (ld) begin
            @(posedge clock); @(negedge clock);
            chk({tag, ".wb"}, {3'b0, obs}, {3'b0, wb});
        end
        @(posedge clock); @(negedge clock);
    endtask

    initial begin
        logic [28:0] z;
        z = '0;
        repeat (2) @(negedge clock);
        chk("reset.hold", {3'b0, obs}, 32'd0);
        @(negedge clock);
        chk("reset.hold2", {3'b0, obs}, 32'd0);
        reset = 1'b0;
        chk("reset.pc", {16'd0, pc}, 32'd0);

        run("ADD",  16'h0152, ev(1, 0, 3'b000, 1, 0, 1, 0, 1, 0, 0, 0), 0, z);
        run("CMP",  16'h01B2, ev(1, 0, 3'b010, 1, 0, 1, 0, 0, 0, 0, 0), 0, z);
        run("SUB",  16'h0192, ev(1, 0, 3'b001, 1, 0, 1, 0, 1, 0, 0, 0), 0, z);
        run("AND",  16'h0112, ev(1, 0, 3'b011, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("OR",   16'h0122, ev(1, 0, 3'b100, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("XOR",  16'h0132, ev(1, 0, 3'b101, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("MOV",  16'h01D2, ev(0, 0, 3'b000, 1, 0, 0, 0, 1, 3'b001, 0, 0), 0, z);
        run("ADDI", 16'h5105, ev(2, 0, 3'b000, 1, 0, 1, 0, 1, 0, 0, 0), 0, z);
        run("ANDI", 16'h1105, ev(3, 0, 3'b011, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("LUI",  16'hF1AB, ev(0, 0, 3'b000, 1, 0, 0, 0, 1, 3'b011, 0, 0), 0, z);
        chk("pc.ten", {16'd0, pc}, 32'd10);

        taken = 1'b1;
        run("BUC",  16'hC0FE, ev(0, 2, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0), 0, z);
        chk("pc.taken", {16'd0, pc}, 32'd9);
        taken = 1'b0;
        run("NOP7", 16'h7000, ev(0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0), 0, z);
        chk("pc.nop", {16'd0, pc}, 32'd10);
        run("BEQ",  16'hC0FE, ev(0, 2, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0), 0, z);
        chk("pc.nottaken", {16'd0, pc}, 32'd11);

        run("CMPI", 16'hB105, ev(2, 0, 3'b010, 1, 0, 1, 0, 0, 0, 0, 0), 0, z);
        run("XORI", 16'h3105, ev(3, 0, 3'b101, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("MOVI", 16'hD1AB, ev(0, 0, 3'b000, 1, 0, 0, 0, 1, 3'b010, 0, 0), 0, z);
        run("LSH",  16'h8142, ev(1, 0, 3'b110, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("LSHI", 16'h8113, ev(2, 0, 3'b110, 1, 0, 0, 0, 1, 0, 0, 0), 0, z);
        run("JCND", 16'h41C2, ev(0, 0, 3'b000, 1, 2, 0, 0, 0, 0, 0, 0), 0, z);
        run("STOR", 16'h4142, ev(0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 1, 1), 0, z);
        run("UND0", 16'h0000, ev(0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0), 0, z);
        run("LOAD", 16'h4102, ev(0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 1, 0), 1,
            ev(0, 0, 3'b000, 0, 0, 0, 0, 1, 3'b100, 1, 0));

        // Abort a load in write-back with an asynchronous reset
        instruction = 16'h4102;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("abort.wb", {31'd0, register_write_enable}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort.async", {3'b0, obs}, 32'd0);
        @(posedge clock); @(negedge clock);
        chk("abort.hold", {3'b0, obs}, 32'd0);
        reset = 1'b0;
        chk("abort.pc", {16'd0, pc}, 32'd0);
        run("ADD2", 16'h0152, ev(1, 0, 3'b000, 1, 0, 1, 0, 1, 0, 0, 0), 0, z);
        chk("pc.after", {16'd0, pc}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
